// File: rtl/cam_pkg.sv
// Shared camera-path types: pixel formats, transmitter states and colour constants
// used by both the stream transmitter and the capture side.
package cam_pkg;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VS,
        ST_VBACK,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VFRONT
    } tx_state_t;

    localparam rgb565_t BAR_WHITE   = 16'hFFFF;
    localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
    localparam rgb565_t BAR_CYAN    = 16'h07FF;
    localparam rgb565_t BAR_GREEN   = 16'h07E0;
    localparam rgb565_t BAR_MAGENTA = 16'hF81F;
    localparam rgb565_t BAR_RED     = 16'hF800;
    localparam rgb565_t BAR_BLUE    = 16'h001F;
    localparam rgb565_t BAR_BLACK   = 16'h0000;

    localparam logic [7:0] RGB332_RED   = 8'hE0;
    localparam logic [7:0] RGB332_GREEN = 8'h1C;
    localparam logic [7:0] RGB332_BLUE  = 8'h03;
    localparam logic [7:0] RGB332_WHITE = 8'hFF;

    function automatic rgb565_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cam_tx_timing.sv
// Frame timing for the camera emulator: phase/slot/line/row counters and frame FSM.
// Latency: state changes on the CLK edge that closes a byte slot (phase 1).
// Backpressure: none; ENABLE is only looked at in IDLE and at the end of the front porch.
module cam_tx_timing
    import cam_pkg::*;
#(
    parameter int WIDTH         = 176,
    parameter int HEIGHT        = 144,
    parameter int H_BLANK       = 16,
    parameter int V_SYNC_LINES  = 3,
    parameter int V_BACK_LINES  = 2,
    parameter int V_FRONT_LINES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    output tx_state_t   state,
    output logic        phase,
    output logic        slot_stb,
    output logic        seg_last,
    output logic        lo_byte,
    output logic [14:0] x,
    output logic [14:0] y
);

    localparam logic [15:0] L_LAST   = 16'(2*WIDTH + H_BLANK - 1);
    localparam logic [15:0] ACT_LAST = 16'(2*WIDTH - 1);
    localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
    localparam logic [15:0] VS_LAST  = 16'(V_SYNC_LINES - 1);
    localparam logic [15:0] VB_LAST  = 16'(V_BACK_LINES - 1);
    localparam logic [15:0] VF_LAST  = 16'(V_FRONT_LINES - 1);
    localparam logic [14:0] X_LAST   = 15'(WIDTH - 1);
    localparam logic [14:0] Y_LAST   = 15'(HEIGHT - 1);

    tx_state_t   state_q, state_d;
    logic        phase_q;
    logic        last_slot;
    logic [15:0] slot_q, line_q;
    logic [14:0] x_q, y_q;

    // last byte slot of the current state's segment
    always_comb begin
        last_slot = 1'b0;
        case (state_q)
            ST_VS:     last_slot = (slot_q == L_LAST) && (line_q == VS_LAST);
            ST_VBACK:  last_slot = (slot_q == L_LAST) && (line_q == VB_LAST);
            ST_ACTIVE: last_slot = (slot_q == ACT_LAST);
            ST_HBLANK: last_slot = (slot_q == HB_LAST);
            ST_VFRONT: last_slot = (slot_q == L_LAST) && (line_q == VF_LAST);
            default:   last_slot = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ENABLE) state_d = ST_VS;
            ST_VS:     if (phase_q && last_slot) state_d = ST_VBACK;
            ST_VBACK:  if (phase_q && last_slot) state_d = ST_ACTIVE;
            ST_ACTIVE: if (phase_q && last_slot) state_d = ST_HBLANK;
            ST_HBLANK: if (phase_q && last_slot) state_d = (y_q == Y_LAST) ? ST_VFRONT : ST_ACTIVE;
            ST_VFRONT: if (phase_q && last_slot) state_d = ENABLE ? ST_VS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            slot_q  <= '0;
            line_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= (state_q != ST_IDLE) && !phase_q;
            // phase 1 only occurs while busy, so this is the slot boundary
            if (phase_q) begin
                if (last_slot) begin
                    slot_q <= '0;
                    line_q <= '0;
                end else if (slot_q == L_LAST) begin
                    slot_q <= '0;
                    line_q <= line_q + 16'd1;
                end else begin
                    slot_q <= slot_q + 16'd1;
                end
                if (state_q == ST_ACTIVE) begin
                    if (last_slot)
                        x_q <= '0;
                    else if (slot_q[0] && (x_q != X_LAST))
                        x_q <= x_q + 15'd1;
                end
                if ((state_q == ST_HBLANK) && last_slot)
                    y_q <= (y_q == Y_LAST) ? 15'd0 : y_q + 15'd1;
            end
        end
    end

    assign state    = state_q;
    assign phase    = phase_q;
    assign slot_stb = phase_q;
    assign seg_last = last_slot;
    assign lo_byte  = slot_q[0];
    assign x        = x_q;
    assign y        = y_q;

endmodule

// File: rtl/cam_stream_tx.sv
// OV7670-style RGB565 byte-stream emulator; CAM_TX_COLOR_BAR_EN adds an internal colour-bar source.
// Latency: pixel requested one CLK before its high byte slot; bytes change on PCLK_OUT low phase.
// Backpressure: none; the pixel source must answer PIX_REQ on the very next CLK.
module cam_stream_tx
    import cam_pkg::*;
#(
    parameter int WIDTH         = 176,
    parameter int HEIGHT        = 144,
    parameter int H_BLANK       = 16,
    parameter int V_SYNC_LINES  = 3,
    parameter int V_BACK_LINES  = 2,
    parameter int V_FRONT_LINES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic        PIX_SRC_SEL,
    output logic        PIX_REQ,
    output logic [14:0] PIX_X,
    output logic [14:0] PIX_Y,
    input  logic [15:0] PIX_IN,
    output logic        PCLK_OUT,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  CAM_DATA,
    output logic        FRAME_DONE,
    output logic        BUSY
);

    localparam logic [14:0] Y_LAST = 15'(HEIGHT - 1);

    tx_state_t   state;
    logic        phase, slot_stb, seg_last, lo_byte, fetch;
    logic [14:0] x, y;
    rgb565_t     pix_src, hold_q;

    cam_tx_timing #(
        .WIDTH        (WIDTH),
        .HEIGHT       (HEIGHT),
        .H_BLANK      (H_BLANK),
        .V_SYNC_LINES (V_SYNC_LINES),
        .V_BACK_LINES (V_BACK_LINES),
        .V_FRONT_LINES(V_FRONT_LINES)
    ) u_timing (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .ENABLE  (ENABLE),
        .state   (state),
        .phase   (phase),
        .slot_stb(slot_stb),
        .seg_last(seg_last),
        .lo_byte (lo_byte),
        .x       (x),
        .y       (y)
    );

    // fetch slot: the slot right before each pixel's high byte
    assign fetch = slot_stb &&
                   (((state == ST_VBACK)  && seg_last) ||
                    ((state == ST_HBLANK) && seg_last && (y != Y_LAST)) ||
                    ((state == ST_ACTIVE) && lo_byte && !seg_last));

`ifdef CAM_TX_COLOR_BAR_EN
    logic [2:0] bar_idx;
    assign bar_idx = 3'((32'(x) * 32'd8) / 32'(WIDTH));
    assign PIX_REQ = fetch && PIX_SRC_SEL;
    assign pix_src = PIX_SRC_SEL ? PIX_IN : bar_color(bar_idx);
`else
    logic unused_src_sel;
    assign unused_src_sel = PIX_SRC_SEL;
    assign PIX_REQ = fetch;
    assign pix_src = PIX_IN;
`endif

    assign PIX_X = PIX_REQ ? ((state == ST_ACTIVE) ? x + 15'd1 : 15'd0) : 15'd0;
    assign PIX_Y = PIX_REQ ? ((state == ST_HBLANK) ? y + 15'd1 : y) : 15'd0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            hold_q <= '0;
        else if ((state == ST_ACTIVE) && !phase && !lo_byte)
            hold_q <= pix_src;
    end

    // PIX_IN is only valid in the high-byte phase 0, so it is passed through there
    always_comb begin
        CAM_DATA = 8'h00;
        if (state == ST_ACTIVE) begin
            if (lo_byte)
                CAM_DATA = hold_q[7:0];
            else if (!phase)
                CAM_DATA = pix_src[15:8];
            else
                CAM_DATA = hold_q[15:8];
        end
    end

    assign PCLK_OUT   = phase;
    assign VSYNC      = (state == ST_VS);
    assign HREF       = (state == ST_ACTIVE);
    assign FRAME_DONE = slot_stb && seg_last && (state == ST_VFRONT);
    assign BUSY       = (state != ST_IDLE);

endmodule
